// File: rtl/four_bit_register_load_arbiter_pkg.sv
// Shared types and constants for the register load arbiter.
// State encoding is fixed so debug dumps stay readable.
package four_bit_reg_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/four_bit_register_load_arbiter_if.sv
// Requester and register-side bundle of the load arbiter.
// master = arbiter side, slave = requesters plus register.
interface four_bit_register_load_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   err;
  logic                   busy;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       reg_I;
  logic                   reg_load;
  logic [WIDTH-1:0]       reg_A;

  modport master (
    input  req, req_data, reg_A,
    output gnt, done, err, busy,
    output owner, reg_I, reg_load
  );

  modport slave (
    output req, req_data, reg_A,
    input  gnt, done, err, busy,
    input  owner, reg_I, reg_load
  );

endinterface

// File: rtl/four_bit_register_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit
// at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int OW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OW-1:0]    ptr_i,
  output logic             any_o,
  output logic [OW-1:0]    idx_o
);

  always_comb begin
    int k;
    k     = 0;
    idx_o = '0;
    // Walk offsets high to low so the nearest one wins
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % N_REQ;
      if (req_i[k]) idx_o = OW'(k);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/four_bit_register_load_arbiter.sv
// Round-robin sequencer sharing one parallel-load register:
// arbitrate, load one cycle, read back, then hold off.
module four_bit_register_load_arbiter
  import four_bit_reg_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  four_bit_register_load_arbiter_if.master bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (HOLD_CYCLES > 0) ?
                      $clog2(HOLD_CYCLES + 1) : 1;

  state_e           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic          pick_any;
  logic [OW-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          data_d  = bus.req_data[pick_idx*WIDTH +: WIDTH];
          state_d = LOAD;
        end
      end
      LOAD: begin
        ptr_d   = (owner_q == OW'(N_REQ - 1)) ?
                  '0 : owner_q + 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (HOLD_CYCLES > 0) begin
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on req
  always_comb begin
    bus.gnt  = '0;
    bus.done = '0;
    if (state_q == LOAD)  bus.gnt[owner_q]  = 1'b1;
    if (state_q == CHECK) bus.done[owner_q] = 1'b1;
  end

  assign bus.err      = (state_q == CHECK) &&
                        (bus.reg_A != data_q);
  assign bus.busy     = (state_q != IDLE);
  assign bus.owner    = owner_q;
  assign bus.reg_I    = data_q;
  assign bus.reg_load = (state_q == LOAD);

endmodule
